// File: rtl/mips_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions for the MIPS pipeline.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dest;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 2-read/1-write register file with synchronous clear and $0 hardwired to zero.
// Define WB_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module reg_file #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs_q[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
        rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];
`ifdef WB_BYPASS_EN
        if (we && (wa != 5'd0) && (wa == ra1)) rd1 = wd;
        if (we && (wa != 5'd0) && (wa == ra2)) rd2 = wd;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: register file, control decode, immediate extension, load-use stall.
// WB_BYPASS_EN (optional) makes same-cycle writebacks visible on reg1/reg2.
module id_stage
    import mips_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc_4_in,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] pc_4,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] sign_extend,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic              RegWrite,
    output logic              MemToReg,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              Branch,
    output logic              ALUSrc,
    output logic              RegDest,
    output logic [2:0]        ALUOp,
    output logic              stall
);

    logic [5:0] opcode;
    logic [4:0] rs;
    logic       uses_rt;
    logic       bubble;
    ctrl_t      dec;
    ctrl_t      ctrl;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign pc_4   = pc_4_in;

    reg_file #(
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W)
    ) u_reg_file (
        .clk  (clk),
        .reset(reset),
        .ra1  (rs),
        .ra2  (rt),
        .we   (wb_reg_write),
        .wa   (wb_addr),
        .wd   (wb_data),
        .rd1  (reg1),
        .rd2  (reg2)
    );

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.reg_dest  = 1'b1;
                dec.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_ANDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_AND;
            end
            OP_ORI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OR;
            end
            OP_SLTI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_SLT;
            end
            default: ;
        endcase
    end

    // Logical immediates are zero-extended; everything else is sign-extended.
    always_comb begin
        if ((opcode == OP_ANDI) || (opcode == OP_ORI)) begin
            sign_extend = {{(DATA_W-16){1'b0}}, instr[15:0]};
        end else begin
            sign_extend = {{(DATA_W-16){instr[15]}}, instr[15:0]};
        end
    end

    // Only R-type, sw and beq actually read rt as a source operand.
    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

    assign stall = ex_mem_read && (ex_rt != 5'd0)
                   && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)))
                   && !flush && !reset;

    assign bubble = stall || flush || reset;
    assign ctrl   = bubble ? '0 : dec;

    assign RegWrite = ctrl.reg_write;
    assign MemToReg = ctrl.mem_to_reg;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign Branch   = ctrl.branch;
    assign ALUSrc   = ctrl.alu_src;
    assign RegDest  = ctrl.reg_dest;
    assign ALUOp    = ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic against a model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, pc_4_in, wb_data;
    logic        flush, ex_mem_read, wb_reg_write;
    logic [4:0]  ex_rt, wb_addr;
    logic [31:0] pc_4, reg1, reg2, sign_extend;
    logic [4:0]  rt, rd;
    logic        RegWrite, MemToReg, MemRead, MemWrite, Branch, ALUSrc, RegDest, stall;
    logic [2:0]  ALUOp;
    logic [9:0]  ctrl_obs;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mregs [32];

    always #5 clk = ~clk;

    assign ctrl_obs = {RegWrite, MemToReg, MemRead, MemWrite, Branch, ALUSrc, RegDest, ALUOp};

    id_stage dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .pc_4_in     (pc_4_in),
        .flush       (flush),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .wb_reg_write(wb_reg_write),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .pc_4        (pc_4),
        .reg1        (reg1),
        .reg2        (reg2),
        .sign_extend (sign_extend),
        .rt          (rt),
        .rd          (rd),
        .RegWrite    (RegWrite),
        .MemToReg    (MemToReg),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Branch      (Branch),
        .ALUSrc      (ALUSrc),
        .RegDest     (RegDest),
        .ALUOp       (ALUOp),
        .stall       (stall)
    );

    // Model: control table {RegWrite,MemToReg,MemRead,MemWrite,Branch,ALUSrc,RegDest,ALUOp}.
    function automatic logic [9:0] model_table(input logic [5:0] op);
        case (op)
            6'b000000: return 10'b1000001_010;
            6'b100011: return 10'b1110010_000;
            6'b101011: return 10'b0001010_000;
            6'b000100: return 10'b0000100_001;
            6'b001000: return 10'b1000010_000;
            6'b001100: return 10'b1000010_011;
            6'b001101: return 10'b1000010_100;
            6'b001010: return 10'b1000010_101;
            default:   return 10'b0;
        endcase
    endfunction

    function automatic logic model_stall();
        logic [5:0] op = instr[31:26];
        logic src_rt = (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100);
        return ex_mem_read && (ex_rt != 0) && !flush && !reset &&
               ((ex_rt == instr[25:21]) || (src_rt && ex_rt == instr[20:16]));
    endfunction

    function automatic logic [9:0] model_ctrl();
        if (reset || flush || model_stall()) return 10'b0;
        return model_table(instr[31:26]);
    endfunction

    function automatic logic [31:0] model_imm();
        logic [5:0] op = instr[31:26];
        if (op == 6'b001100 || op == 6'b001101) return {16'h0, instr[15:0]};
        return {{16{instr[15]}}, instr[15:0]};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (wb_reg_write && wb_addr == a) return wb_data;
`endif
        return mregs[a];
    endfunction

    task automatic idle_inputs();
        reset = 0; instr = 32'h0; pc_4_in = 32'h0; flush = 0; ex_mem_read = 0;
        ex_rt = 0; wb_reg_write = 0; wb_addr = 0; wb_data = 0;
    endtask

    // Advance one clock, commit the edge to the model, return at the following negedge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        end else if (wb_reg_write && wb_addr != 0) begin
            mregs[wb_addr] = wb_data;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        instr = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
        wb_reg_write = 1; wb_addr = 5'd1; wb_data = 32'hFFFF_FFFF;
        tick();
        #1;
        n_tests++;
        if (ctrl_obs !== 10'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ctrl=%b stall=%b, want 0/0", ctrl_obs, stall);
        end
        n_tests++;
        if (reg1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_reg1: got %h want 0", reg1);
        end
        reset = 0; wb_reg_write = 0;
        #1;
        n_tests++;
        if (reg1 !== 32'h0 || reg2 !== 32'h0 || stall !== 1'b0 || ctrl_obs !== 10'b1000001_010) begin
            n_fail++;
            $display("FAIL reset_add: reg1=%h reg2=%h stall=%b ctrl=%b want 0 0 0 1000001010",
                     reg1, reg2, stall, ctrl_obs);
        end
        tick();
    endtask

    task automatic test_writeback();
        idle_inputs();
        wb_reg_write = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_addr = 5'd0; wb_data = 32'h1234;
        tick();
        wb_reg_write = 0;
        instr = {6'b001000, 5'd5, 5'd0, 16'h0};
        #1;
        n_tests++;
        if (reg1 !== 32'hDEAD_BEEF || reg2 !== 32'h0) begin
            n_fail++;
            $display("FAIL writeback_r0: reg1=%h reg2=%h want deadbeef 0", reg1, reg2);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp;
        idle_inputs();
        wb_reg_write = 1; wb_addr = 5'd7; wb_data = 32'h11;
        tick();
        wb_data = 32'h22;
        instr = {6'b001000, 5'd7, 5'd0, 16'h0};
        #1;
`ifdef WB_BYPASS_EN
        exp = 32'h22;
`else
        exp = 32'h11;
`endif
        n_tests++;
        if (reg1 !== exp) begin
            n_fail++;
            $display("FAIL same_cycle_rd: reg1=%h want %h", reg1, exp);
        end
        tick();
        wb_reg_write = 0;
        #1;
        n_tests++;
        if (reg1 !== 32'h22) begin
            n_fail++;
            $display("FAIL after_write_rd: reg1=%h want 22", reg1);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        ex_mem_read = 1; ex_rt = 5'd4;
        instr = {6'b101011, 5'd9, 5'd4, 16'h0};
        #1;
        n_tests++;
        if (stall !== 1'b1 || ctrl_obs !== 10'b0) begin
            n_fail++;
            $display("FAIL load_use_sw: stall=%b ctrl=%b want 1 0", stall, ctrl_obs);
        end
        instr = {6'b001000, 5'd9, 5'd4, 16'h1};
        #1;
        n_tests++;
        if (stall !== 1'b0 || ALUSrc !== 1'b1 || ctrl_obs !== 10'b1000010_000) begin
            n_fail++;
            $display("FAIL load_use_addi: stall=%b ctrl=%b want 0 1000010000", stall, ctrl_obs);
        end
        ex_rt = 5'd0;
        instr = {6'b001000, 5'd0, 5'd0, 16'h1};
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_r0: stall=%b want 0", stall);
        end
        tick();
    endtask

    task automatic test_flush();
        idle_inputs();
        ex_mem_read = 1; ex_rt = 5'd4; flush = 1;
        instr = {6'd0, 5'd4, 5'd4, 5'd6, 5'd0, 6'h20};
        #1;
        n_tests++;
        if (stall !== 1'b0 || ctrl_obs !== 10'b0) begin
            n_fail++;
            $display("FAIL flush_prio: stall=%b ctrl=%b want 0 0", stall, ctrl_obs);
        end
        flush = 0; ex_mem_read = 0;
        instr = {6'b111111, 26'h3ff_ffff};
        #1;
        n_tests++;
        if (ctrl_obs !== 10'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL unknown_op: ctrl=%b stall=%b want 0 0", ctrl_obs, stall);
        end
        tick();
    endtask

    task automatic test_imm();
        idle_inputs();
        instr = {6'b001101, 5'd0, 5'd1, 16'h8000};
        #1;
        n_tests++;
        if (sign_extend !== 32'h0000_8000) begin
            n_fail++;
            $display("FAIL imm_ori: got %h want 00008000", sign_extend);
        end
        instr = {6'b100011, 5'd0, 5'd1, 16'h8000};
        #1;
        n_tests++;
        if (sign_extend !== 32'hFFFF_8000) begin
            n_fail++;
            $display("FAIL imm_lw: got %h want ffff8000", sign_extend);
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] ops [9];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                6'b001100, 6'b001101, 6'b001010, 6'b110111};
        for (int n = 0; n < 300; n++) begin
            idle_inputs();
            instr = $urandom;
            instr[31:26] = ops[$urandom_range(0, 8)];
            instr[25:21] = 5'($urandom_range(0, 7));
            instr[20:16] = 5'($urandom_range(0, 7));
            pc_4_in      = $urandom;
            ex_mem_read  = $urandom_range(0, 1) == 1;
            ex_rt        = 5'($urandom_range(0, 7));
            flush        = $urandom_range(0, 7) == 0;
            wb_reg_write = $urandom_range(0, 1) == 1;
            wb_addr      = 5'($urandom_range(0, 7));
            wb_data      = $urandom;
            reset        = $urandom_range(0, 63) == 0;
            #1;
            n_tests++;
            if (ctrl_obs !== model_ctrl() || stall !== model_stall()) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: ctrl=%b stall=%b want %b %b instr=%h",
                         n, ctrl_obs, stall, model_ctrl(), model_stall(), instr);
            end
            n_tests++;
            if (reg1 !== model_read(instr[25:21]) || reg2 !== model_read(instr[20:16])) begin
                n_fail++;
                $display("FAIL rand_read[%0d]: reg1=%h reg2=%h want %h %h", n, reg1, reg2,
                         model_read(instr[25:21]), model_read(instr[20:16]));
            end
            n_tests++;
            if (sign_extend !== model_imm() || rt !== instr[20:16] || rd !== instr[15:11]
                || pc_4 !== pc_4_in) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: imm=%h rt=%0d rd=%0d pc4=%h want %h %0d %0d %h",
                         n, sign_extend, rt, rd, pc_4, model_imm(), instr[20:16],
                         instr[15:11], pc_4_in);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_writeback();
        test_same_cycle();
        test_load_use();
        test_flush();
        test_imm();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
